// File: rtl/wb_gain_pipe.sv
// Two-stage white-balance gain pipeline with per-channel gains that switch at the start of a frame.
// Optional macro WB_GAIN_ROUND_EN selects round-half-up instead of truncation before saturation.
module wb_gain_pipe #(
  parameter int DATA_W = 8,
  parameter int GAIN_W = 8,
  parameter int FRAC_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [1:0]        in_color,
  input  logic [DATA_W-1:0] in_value,
  input  logic              gain_valid,
  input  logic [GAIN_W-1:0] gain_r,
  input  logic [GAIN_W-1:0] gain_g,
  input  logic [GAIN_W-1:0] gain_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic [1:0]        out_color,
  output logic [DATA_W-1:0] out_value,
  output logic              out_sat
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1) << FRAC_W;
  localparam logic [PROD_W-1:0] MAX_V = {{(PROD_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
`ifdef WB_GAIN_ROUND_EN
  localparam logic [PROD_W-1:0] RND = PROD_W'(1) << (FRAC_W - 1);
`else
  localparam logic [PROD_W-1:0] RND = '0;
`endif

  logic [GAIN_W-1:0] act_r_q, act_g_q, act_b_q, act_r_d, act_g_d, act_b_d;
  logic [GAIN_W-1:0] pnd_r_q, pnd_g_q, pnd_b_q, pnd_r_d, pnd_g_d, pnd_b_d;
  logic              pnd_flag_q, pnd_flag_d;
  logic              s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d;
  logic [1:0]        s1_color_q, s1_color_d;
  logic [DATA_W-1:0] s1_value_q, s1_value_d;
  logic [GAIN_W-1:0] s1_gain_q, s1_gain_d, sel_gain;
  logic              out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_sat_q, out_sat_d;
  logic [1:0]        out_color_q, out_color_d;
  logic [DATA_W-1:0] out_value_q, out_value_d;
  logic              en, sof_take;
  logic [PROD_W-1:0] prod, shifted;
  logic [DATA_W-1:0] res_value;
  logic              res_sat;

  assign en       = !out_valid_q || out_ready;
  assign sof_take = in_valid && en && in_sof;

  // Gain bookkeeping: an accepted SOF beat promotes the strobed or pending gains to active.
  always_comb begin
    act_r_d = act_r_q; act_g_d = act_g_q; act_b_d = act_b_q;
    pnd_r_d = pnd_r_q; pnd_g_d = pnd_g_q; pnd_b_d = pnd_b_q;
    pnd_flag_d = pnd_flag_q;
    if (sof_take) begin
      pnd_flag_d = 1'b0;
      if (gain_valid) begin
        act_r_d = gain_r; act_g_d = gain_g; act_b_d = gain_b;
      end else if (pnd_flag_q) begin
        act_r_d = pnd_r_q; act_g_d = pnd_g_q; act_b_d = pnd_b_q;
      end else begin
        act_r_d = act_r_q;
      end
    end else if (gain_valid) begin
      pnd_r_d = gain_r; pnd_g_d = gain_g; pnd_b_d = gain_b;
      pnd_flag_d = 1'b1;
    end else begin
      pnd_flag_d = pnd_flag_q;
    end
    case (in_color)
      2'd0:    sel_gain = act_r_d;
      2'd1:    sel_gain = act_g_d;
      2'd2:    sel_gain = act_b_d;
      default: sel_gain = UNITY;
    endcase
  end

  // Gain multiply, optional rounding, shift and clip for the beat held in S1.
  always_comb begin
    prod    = PROD_W'(s1_value_q) * PROD_W'(s1_gain_q) + RND;
    shifted = prod >> FRAC_W;
    if (s1_color_q == 2'd3) begin
      res_value = s1_value_q;
      res_sat   = 1'b0;
    end else if (shifted > MAX_V) begin
      res_value = {DATA_W{1'b1}};
      res_sat   = 1'b1;
    end else begin
      res_value = shifted[DATA_W-1:0];
      res_sat   = 1'b0;
    end
  end

  // Both stages advance together on en, otherwise hold.
  always_comb begin
    s1_valid_d = s1_valid_q; s1_sof_d = s1_sof_q; s1_color_d = s1_color_q;
    s1_value_d = s1_value_q; s1_gain_d = s1_gain_q;
    out_valid_d = out_valid_q; out_sof_d = out_sof_q; out_color_d = out_color_q;
    out_value_d = out_value_q; out_sat_d = out_sat_q;
    if (en) begin
      s1_valid_d  = in_valid;
      s1_sof_d    = in_sof;
      s1_color_d  = in_color;
      s1_value_d  = in_value;
      s1_gain_d   = sel_gain;
      out_valid_d = s1_valid_q;
      out_sof_d   = s1_sof_q;
      out_color_d = s1_color_q;
      out_value_d = res_value;
      out_sat_d   = res_sat;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_r_q <= UNITY; act_g_q <= UNITY; act_b_q <= UNITY;
      pnd_r_q <= UNITY; pnd_g_q <= UNITY; pnd_b_q <= UNITY;
      pnd_flag_q  <= 1'b0;
      s1_valid_q  <= 1'b0; s1_sof_q <= 1'b0; s1_color_q <= 2'd0;
      s1_value_q  <= '0;   s1_gain_q <= UNITY;
      out_valid_q <= 1'b0; out_sof_q <= 1'b0; out_color_q <= 2'd0;
      out_value_q <= '0;   out_sat_q <= 1'b0;
    end else begin
      act_r_q <= act_r_d; act_g_q <= act_g_d; act_b_q <= act_b_d;
      pnd_r_q <= pnd_r_d; pnd_g_q <= pnd_g_d; pnd_b_q <= pnd_b_d;
      pnd_flag_q  <= pnd_flag_d;
      s1_valid_q  <= s1_valid_d; s1_sof_q <= s1_sof_d; s1_color_q <= s1_color_d;
      s1_value_q  <= s1_value_d; s1_gain_q <= s1_gain_d;
      out_valid_q <= out_valid_d; out_sof_q <= out_sof_d; out_color_q <= out_color_d;
      out_value_q <= out_value_d; out_sat_q <= out_sat_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_color = out_color_q;
  assign out_value = out_value_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_wb_gain_pipe.sv
// Randomized and directed bench for wb_gain_pipe against a frame-level gain model and output scoreboard.
module tb_wb_gain_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready, in_sof = 1'b0;
  logic [1:0] in_color = 2'd0;
  logic [7:0] in_value = 8'd0;
  logic       gain_valid = 1'b0;
  logic [7:0] gain_r = 8'd0, gain_g = 8'd0, gain_b = 8'd0;
  logic       out_valid, out_ready = 1'b1, out_sof, out_sat;
  logic [1:0] out_color;
  logic [7:0] out_value;

  wb_gain_pipe #(.DATA_W(8), .GAIN_W(8), .FRAC_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_color(in_color), .in_value(in_value), .gain_valid(gain_valid), .gain_r(gain_r),
    .gain_g(gain_g), .gain_b(gain_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_color(out_color), .out_value(out_value), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

`ifdef WB_GAIN_ROUND_EN
  localparam int RND = 32;
`else
  localparam int RND = 0;
`endif

  typedef struct {
    int val; int sat; int sof; int color; int acc_cyc; bit lat;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0, n_pass = 0, cyc = 0;
  int   m_act[3], m_pnd[3];
  bit   m_flag = 1'b0, lat_mode = 1'b1, hold_pend = 1'b0;
  int   last_val = -1, last_sat = -1;
  logic [7:0] sv_val; logic [1:0] sv_col; logic sv_sof, sv_sat;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin m_act[i] = 64; m_pnd[i] = 64; end
    m_flag = 1'b0;
  endfunction

  // One clock: drive, sample at negedge, score outputs, model the accepted beat.
  task automatic step(input bit v, input bit s, input int c, input int val, input bit gv,
                      input int gr, input int gg, input int gb, input bit ordy);
    exp_t e;
    int g, p;
    in_valid = v; in_sof = s; in_color = 2'(c); in_value = 8'(val);
    gain_valid = gv; gain_r = 8'(gr); gain_g = 8'(gg); gain_b = 8'(gb); out_ready = ordy;
    @(negedge clk);
    if (hold_pend) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_value", int'(out_value), int'(sv_val));
      chk("hold_meta", int'({out_sof, out_sat, out_color}), int'({sv_sof, sv_sat, sv_col}));
    end
    if (out_valid && !out_ready) chk("stall_rdy", int'(in_ready), 0);
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", int'(out_valid), 0);
      else begin
        e = q.pop_front();
        chk("value", int'(out_value), e.val);
        chk("sat", int'(out_sat), e.sat);
        chk("sof_color", int'({out_sof, out_color}), e.sof * 4 + e.color);
        if (e.lat) chk("latency", cyc - e.acc_cyc, 2);
        last_val = int'(out_value); last_sat = int'(out_sat);
      end
    end
    if (v && in_ready && s) begin
      if (gv) begin m_act[0] = gr; m_act[1] = gg; m_act[2] = gb; end
      else if (m_flag) m_act = m_pnd;
      m_flag = 1'b0;
    end else if (gv) begin
      m_pnd[0] = gr; m_pnd[1] = gg; m_pnd[2] = gb; m_flag = 1'b1;
    end
    if (v && in_ready) begin
      e.sof = s; e.color = c; e.acc_cyc = cyc; e.lat = lat_mode;
      if (c == 3) begin e.val = val; e.sat = 0; end
      else begin
        g = m_act[c];
        p = (val * g + RND) / 64;
        if (p > 255) begin e.val = 255; e.sat = 1; end
        else begin e.val = p; e.sat = 0; end
      end
      q.push_back(e);
    end
    hold_pend = out_valid && !out_ready;
    sv_val = out_value; sv_col = out_color; sv_sof = out_sof; sv_sat = out_sat;
    @(posedge clk); #1; cyc++;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1'b1);
    chk("drain_left", q.size(), 0);
  endtask

  task automatic do_reset(input int cycles);
    in_valid = 1'b0; gain_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_value", int'(out_value), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    q.delete(); model_reset(); hold_pend = 1'b0;
    @(posedge clk); #1; cyc++;
  endtask

  initial begin
    model_reset();
    do_reset(2);
    lat_mode = 1'b1;
    step(1, 0, 0, 100, 0, 0, 0, 0, 1); drain();
    chk("unity_r100", last_val, 100); chk("unity_sat", last_sat, 0);

    step(0, 0, 0, 0, 1, 128, 64, 64, 1);
    step(1, 1, 0, 100, 0, 0, 0, 0, 1); drain(); chk("g128_sof100", last_val, 200);
    step(1, 0, 0, 200, 0, 0, 0, 0, 1); drain();
    chk("g128_200_clip", last_val, 255); chk("g128_200_sat", last_sat, 1);

    step(0, 0, 0, 0, 1, 32, 64, 64, 1);
    step(1, 0, 0, 100, 0, 0, 0, 0, 1); drain(); chk("pending_not_yet", last_val, 200);
    step(1, 1, 0, 100, 0, 0, 0, 0, 1); drain(); chk("pending_at_sof", last_val, 50);

    step(1, 1, 0, 3, 1, 96, 64, 64, 1); drain();
    chk("g96_v3_same_cycle", last_val, (RND != 0) ? 5 : 4);
    step(1, 0, 3, 77, 0, 0, 0, 0, 1); drain();
    chk("bypass_77", last_val, 77); chk("bypass_sat", last_sat, 0);
    step(1, 1, 0, 200, 1, 0, 64, 64, 1); drain(); chk("gain0", last_val, 0);

    lat_mode = 1'b0;
    step(1, 0, 1, 10, 0, 0, 0, 0, 1);
    step(1, 0, 1, 20, 0, 0, 0, 0, 1);
    step(1, 0, 1, 30, 0, 0, 0, 0, 0);
    step(1, 0, 1, 40, 0, 0, 0, 0, 0);
    step(1, 0, 1, 50, 0, 0, 0, 0, 0);
    step(1, 0, 1, 60, 0, 0, 0, 0, 1);
    drain(); chk("stall_last", last_val, 60);

    step(1, 0, 0, 90, 0, 0, 0, 0, 0);
    step(1, 0, 0, 91, 0, 0, 0, 0, 0);
    do_reset(1);
    lat_mode = 1'b1;
    step(1, 0, 0, 100, 0, 0, 0, 0, 1); drain(); chk("post_reset_unity", last_val, 100);

    lat_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)), bit'($urandom_range(0, 15) == 0), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), bit'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_gain_pipe.md
WB_GAIN_PIPE -- requirements
Module: wb_gain_pipe

Interface
REQ-001 Parameter DATA_W, default 8: pixel value width in bits.
REQ-002 Parameter GAIN_W, default 8: gain width in bits, unsigned fixed point.
REQ-003 Parameter FRAC_W, default 6: fractional bits of the gain; unity is 1<<FRAC_W.
REQ-004 clk  input  1  the single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_sof  input  1  beat is the first pixel of a frame.
REQ-009 in_color  input  2  0=R, 1=G, 2=B, 3=bypass.
REQ-010 in_value  input  DATA_W  raw pixel value.
REQ-011 gain_valid  input  1  one-cycle strobe that loads gain_r, gain_g and gain_b into the pending registers.
REQ-012 gain_r, gain_g, gain_b  input  GAIN_W each  new per-channel gains.
REQ-013 out_valid  output  1  output beat valid.
REQ-014 out_ready  input  1  downstream accepts the output beat.
REQ-015 out_sof, out_color  output  1, 2  in_sof and in_color delayed in step with the pixel.
REQ-016 out_value  output  DATA_W  gained and saturated pixel.
REQ-017 out_sat  output  1  out_value was clipped.

Function
REQ-018 Two-stage pipeline: S1 registers the beat and the selected active gain; S2 registers the product after shift, rounding and saturation.
REQ-019 Latency is 2 cycles from input acceptance to out_valid while out_ready is held high; throughput is 1 beat per cycle.
REQ-020 A beat is accepted when in_valid and in_ready are both high; an output beat is consumed when out_valid and out_ready are both high.
REQ-021 Stall enable: en = !out_valid | out_ready; in_ready equals en; S1 and S2 advance only when en is high.
REQ-022 While stalled, out_value, out_color, out_sof, out_sat and out_valid hold stable; no beat is lost or duplicated.
REQ-023 Result = (value * gain) >> FRAC_W, computed at DATA_W+GAIN_W bits with no intermediate truncation.
REQ-024 If the result exceeds 2^DATA_W-1, out_value is 2^DATA_W-1 and out_sat is 1; otherwise out_sat is 0.
REQ-025 in_color 3 passes the value unchanged, with out_sat 0.
REQ-026 A gain_valid strobe writes the pending gains and sets the pending flag; a later strobe overwrites the pending gains.
REQ-027 When an accepted beat has in_sof high and the pending flag is set, the pending gains are copied to the active gains and the flag is cleared.
REQ-028 That SOF beat and every following beat use the new gains; beats before it use the old gains.
REQ-029 If gain_valid and an accepted SOF beat occur in the same cycle, the strobed gains apply to that SOF beat directly.
REQ-030 A gain_valid strobe does not alter gains applied to beats already in S1 or S2.
REQ-031 Gain value 0 yields out_value 0.

Reset
REQ-032 While rst_n is low at a clock edge, registers take these values: out_valid 0, out_value 0, out_color 0, out_sof 0, out_sat 0, S1 valid 0.
REQ-033 Reset also sets active and pending gains to unity and clears the pending flag.
REQ-034 Reset mid-operation discards all in-flight beats; in_ready is 1 in the first cycle after reset.

Configuration
REQ-035 Macro WB_GAIN_ROUND_EN: when defined, 1<<(FRAC_W-1) is added to the product before the shift (round half up, then saturate).
REQ-036 When WB_GAIN_ROUND_EN is not defined, the result is truncated.
REQ-037 Latency and interface are identical with and without WB_GAIN_ROUND_EN.

Verification (DATA_W=8, GAIN_W=8, FRAC_W=6)
REQ-038 After reset, no gain_valid; R beat of value 100 -> out_value 100, out_sat 0, 2 cycles after acceptance.
REQ-039 gain_valid with R=128; then SOF R beat 100 -> 200; next R beat 200 -> 255 with out_sat 1.
REQ-040 Mid-frame gain_valid with R=32; non-SOF R beat 100 -> still 200; next SOF R beat 100 -> 50.
REQ-041 out_ready low for 3 cycles with valid output -> output held stable, in_ready 0, all beats emerge in order with none dropped.
REQ-042 Gain 96 with value 3 -> out_value 5 with WB_GAIN_ROUND_EN defined, 4 without; bypass color 3 with value 77 -> 77.
REQ-043 rst_n low for one cycle with both stages full -> out_valid 0 next cycle; next R beat 100 -> 100 (unity gain).
